// File: rtl/paint_sequencer_pkg.sv
// paint_sequencer_pkg: panel geometry, FSM state encoding and pixel tag layout shared by the sequencer files
package paint_sequencer_pkg;
  localparam int PANEL_W_BITS = 6;
  localparam int PANEL_H_BITS = 6;
  localparam int RGB_W = 24;
  localparam int TAG_W = PANEL_W_BITS + PANEL_H_BITS + 2;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  typedef struct packed {
    logic [PANEL_W_BITS-1:0] x;
    logic [PANEL_H_BITS-1:0] y;
    logic sof;
    logic eof;
  } tag_t;
endpackage

// File: rtl/paint_sequencer_if.sv
// paint_sequencer_if: pixel stream (valid/ready, rgb24, x/y, sof/eol/eof); master = sequencer, slave = panel writer
interface paint_sequencer_if;
  import paint_sequencer_pkg::*;
  logic pix_valid;
  logic pix_ready;
  logic [RGB_W-1:0] pix_rgb24;
  logic [PANEL_W_BITS-1:0] pix_x;
  logic [PANEL_H_BITS-1:0] pix_y;
  logic pix_sof;
  logic pix_eol;
  logic pix_eof;
  modport master (output pix_valid, pix_rgb24, pix_x, pix_y, pix_sof, pix_eol, pix_eof, input pix_ready);
  modport slave (input pix_valid, pix_rgb24, pix_x, pix_y, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous FIFO (clk, rst, wr_en/wr_data in, rd_en in, rd_data = head, count = occupancy)
module pix_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  overflow_a: assert property (@(posedge clk) disable iff (rst) !(wr_en && !rd_en && count == CW'(DEPTH)));
  underflow_a: assert property (@(posedge clk) disable iff (rst) !(rd_en && count == '0));
endmodule

// File: rtl/paint_sequencer.sv
// paint_sequencer: raster frame/subframe/x/y generator for a fixed-latency painter; ports clk, reset, enable, frame, subframe, x, y, rgb24 in, pix stream (master), busy
module paint_sequencer
  import paint_sequencer_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int SUBFRAMES = 8,
  parameter int PAINT_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic [FRAME_BITS-1:0] frame,
  output logic [7:0] subframe,
  output logic [PANEL_W_BITS-1:0] x,
  output logic [PANEL_H_BITS-1:0] y,
  input  logic [RGB_W-1:0] rgb24,
  paint_sequencer_if.master pix,
  output logic busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SR_D = PAINT_LATENCY == 0 ? 1 : PAINT_LATENCY;
  localparam int ENTRY_W = RGB_W + TAG_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [7:0] SUB_LAST = 8'(SUBFRAMES - 1);
  state_t state;
  logic [CW-1:0] inflight, count;
  logic [CW:0] used;
  logic issue, wr_en, last_px, valid;
  tag_t cur, wr_tag, rd_tag;
  tag_t sr_t [SR_D];
  logic [SR_D-1:0] sr_v;
  logic [ENTRY_W-1:0] rd_data;
  assign last_px = &x && &y;
  assign cur = {x, y, ~|x && ~|y, last_px};
  // every issued pixel owns a FIFO slot from issue onward, so the painter never needs to stall
  assign used = {1'b0, inflight} + {1'b0, count};
  assign issue = state == SCAN && used < DEPTH_C;
  generate
    if (PAINT_LATENCY == 0) begin : g_direct
      assign wr_en = issue;
      assign wr_tag = cur;
    end else begin : g_pipe
      assign wr_en = sr_v[PAINT_LATENCY-1];
      assign wr_tag = sr_t[PAINT_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_v <= '0;
      inflight <= '0;
    end else begin
      sr_v[0] <= issue;
      sr_t[0] <= cur;
      for (int i = 1; i < SR_D; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_t[i] <= sr_t[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(wr_en);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      frame <= '0;
      subframe <= '0;
      x <= '0;
      y <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= SCAN;
          busy <= 1'b1;
        end
        SCAN: if (issue) begin
          x <= x + 1'b1;
          if (&x) y <= y + 1'b1;
          if (last_px) begin
            subframe <= subframe == SUB_LAST ? '0 : subframe + 1'b1;
            if (subframe == SUB_LAST) frame <= frame + 1'b1;
            if (!enable) state <= DRAIN;
          end
        end
        DRAIN: if (inflight == '0 && count == '0) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
  pix_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .wr_en(wr_en),
    .wr_data({rgb24, wr_tag}),
    .rd_en(valid && pix.pix_ready),
    .rd_data(rd_data),
    .count(count)
  );
  assign valid = count != '0;
  assign rd_tag = rd_data[TAG_W-1:0];
  assign pix.pix_valid = valid;
  assign pix.pix_rgb24 = rd_data[ENTRY_W-1:TAG_W];
  assign pix.pix_x = rd_tag.x;
  assign pix.pix_y = rd_tag.y;
  assign pix.pix_sof = valid && rd_tag.sof;
  assign pix.pix_eol = valid && &rd_tag.x;
  assign pix.pix_eof = valid && rd_tag.eof;
endmodule

// File: tb/tb_paint_sequencer.sv
// tb_paint_sequencer: scoreboard bench with raster reference model, random backpressure, wrap, early drop and mid-scan reset
module tb_paint_sequencer;
  import paint_sequencer_pkg::*;
  localparam int FB = 2;
  localparam int SUB = 2;
  localparam int L = 1;
  localparam int DEPTH = 4;
  localparam int NPX = 4096;
  typedef struct packed {
    logic [23:0] rgb;
    logic [5:0] x;
    logic [5:0] y;
    logic sof;
    logic eol;
    logic eof;
  } px_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [FB-1:0] frame;
  logic [7:0] subframe;
  logic [5:0] x, y;
  logic [23:0] rgb24;
  logic busy;
  int total, bad, rmode, iss, rx_done, rx_run, cyc, first_cyc, last_cyc, max_out, max_cnt, m_frame, m_sub;
  px_t exp_q[$];
  px_t first_px;
  paint_sequencer_if pix();
  paint_sequencer #(.FRAME_BITS(FB), .SUBFRAMES(SUB), .PAINT_LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame(frame), .subframe(subframe),
    .x(x), .y(y), .rgb24(rgb24), .pix(pix), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rgb24 <= {4'(frame), subframe, y, x};
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic push_model(input int n);
    px_t e;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < NPX; k++) begin
        e.x = 6'(k % 64);
        e.y = 6'(k / 64);
        e.rgb = {4'(m_frame), 8'(m_sub), e.y, e.x};
        e.sof = k == 0;
        e.eol = k % 64 == 63;
        e.eof = k == NPX - 1;
        exp_q.push_back(e);
      end
      if (m_sub == SUB - 1) begin
        m_sub = 0;
        m_frame = (m_frame + 1) % (1 << FB);
      end else m_sub++;
    end
  endtask
  initial begin
    pix.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix.pix_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom_range(0, 99) < 30) : 1'b0;
    end
  end
  initial begin
    px_t cur, held;
    logic stall;
    logic [5:0] px_prev;
    stall = 1'b0;
    px_prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        iss = 0;
        rx_done = 0;
        px_prev = '0;
        stall = 1'b0;
      end else begin
        if (x != px_prev) iss++;
        px_prev = x;
        if (iss - rx_done > max_out) max_out = iss - rx_done;
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
        cur = {pix.pix_rgb24, pix.pix_x, pix.pix_y, pix.pix_sof, pix.pix_eol, pix.pix_eof};
        if (stall) chk("hold_stable", 64'(cur), 64'(held));
        stall = pix.pix_valid && !pix.pix_ready;
        held = cur;
        if (pix.pix_valid && pix.pix_ready) begin
          if (exp_q.size() == 0) chk("unexpected_pixel", 64'(cur), 64'(0));
          else chk("pixel", 64'(cur), 64'(exp_q.pop_front()));
          if (rx_run == 0) begin
            first_cyc = cyc;
            first_px = cur;
          end
          last_cyc = cyc;
          rx_run++;
          rx_done++;
        end
      end
    end
  end
  task automatic run(input int n, input int mode);
    int lat, t, iss0;
    rmode = mode;
    push_model(n);
    rx_run = 0;
    iss0 = iss;
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!pix.pix_valid && lat < 20);
    chk("first_valid_latency", 64'(lat), 64'(L + 2));
    t = 0;
    while (rx_run < (n - 1) * NPX + 330 && t < 80000) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 80000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t < 80000), 64'(1));
    chk("busy_after_drain", 64'(busy), 64'(0));
    chk("pixel_count", 64'(rx_run), 64'(n * NPX));
    chk("issue_count", 64'(iss - iss0), 64'(n * NPX));
    chk("xy_after_sweep", 64'({x, y}), 64'(0));
    chk("frame_after_run", 64'(frame), 64'(m_frame));
    chk("subframe_after_run", 64'(subframe), 64'(m_sub));
    if (mode == 0) chk("no_bubble", 64'(last_cyc - first_cyc), 64'(n * NPX - 1));
    exp_q.delete();
  endtask
  initial begin
    int vcnt;
    rmode = 2;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_frame", 64'(frame), 64'(0));
    chk("reset_subframe", 64'(subframe), 64'(0));
    chk("reset_xy", 64'({x, y}), 64'(0));
    chk("reset_valid", 64'(pix.pix_valid), 64'(0));
    chk("reset_flags", 64'({pix.pix_sof, pix.pix_eol, pix.pix_eof}), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    vcnt = 0;
    repeat (100) begin
      @(negedge clk);
      vcnt += int'(pix.pix_valid);
    end
    chk("idle_valid_cycles", 64'(vcnt), 64'(0));
    run(1, 0);
    max_out = 0;
    max_cnt = 0;
    run(1, 1);
    chk("max_outstanding", 64'(max_out <= DEPTH), 64'(1));
    chk("max_fifo_count", 64'(max_cnt <= DEPTH), 64'(1));
    run(8, 0);
    rmode = 2;
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (30) @(negedge clk);
    chk("stall_x", 64'({x, y}), 64'({6'(DEPTH), 6'd0}));
    chk("stall_fifo_full", 64'(dut.u_fifo.count), 64'(DEPTH));
    @(posedge clk);
    #1 begin
      reset = 1'b1;
      enable = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("midreset_valid", 64'(pix.pix_valid), 64'(0));
    chk("midreset_xy_frame", 64'({x, y, frame, subframe}), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    m_frame = 0;
    m_sub = 0;
    run(1, 0);
    chk("first_after_reset", 64'({first_px.x, first_px.y, first_px.sof}), 64'({12'd0, 1'b1}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/paint_sequencer.md
# paint_sequencer

Sequences a 24-bit pixel painter over the 64×64 panel: it generates the `frame`, `subframe`, `x` and `y` stimulus a painter consumes, and tracks the painter's fixed pipeline latency. It captures each `rgb24` result with its coordinates into a small output FIFO and presents pixels to the downstream panel/PWM writer over a valid/ready handshake. A credit scheme means backpressure never drops a pixel, even though the painter itself cannot stall.

## Interface

- `FRAME_BITS`, 16: width of the frame counter.
- `SUBFRAMES`, 8: subframe sweeps per frame (`subframe` counts 0..SUBFRAMES-1, max 256).
- `PAINT_LATENCY`, 1: clocks from stable `x`/`y` at the painter to valid `rgb24`; legal range 0..4.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥ `PAINT_LATENCY`+2.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run request.
- `frame` out FRAME_BITS: frame number to painter.
- `subframe` out 8: subframe number to painter.
- `x` out 6: column to painter.
- `y` out 6: row to painter.
- `rgb24` in 24: painter result `{b,g,r}`.
- `pix_valid` out 1: output pixel available.
- `pix_ready` in 1: downstream accepts pixel.
- `pix_rgb24` out 24: pixel colour.
- `pix_x` out 6: pixel column.
- `pix_y` out 6: pixel row.
- `pix_sof` out 1: first pixel (0,0) of a subframe.
- `pix_eol` out 1: `pix_x`==63.
- `pix_eof` out 1: last pixel (63,63) of a subframe.
- `busy` out 1: state ≠ IDLE.

## Operation

- **States:**
  - IDLE→SCAN when `enable`=1.
  - SCAN→DRAIN when the (63,63) issue completes and `enable`=0.
  - DRAIN→IDLE when no pixels are in flight and the FIFO is empty.
  - SCAN stays in SCAN if `enable`=1 at the end of a subframe, with no bubble.
- **Issue:** in SCAN, one coordinate issues per cycle when `credits`>0.
  - `credits` = FIFO_DEPTH − in-flight − FIFO occupancy.
  - Raster order: x fastest (0..63), then y (0..63).
  - With no credit, `x`/`y` hold and no issue is recorded.
- **Tracking:** each issue pushes `{x,y,sof,eof}` into a valid shift register `PAINT_LATENCY` deep. When the tagged slot emerges, `rgb24` is written into the FIFO together with that tag.
- **Counter advance:** after issuing (63,63), `subframe` increments.
  - When `subframe` was SUBFRAMES-1, it wraps to 0 and `frame` increments.
  - `frame` wraps modulo 2^FRAME_BITS; 0xFFFF goes to 0x0000.
- **Enable deassertion:** dropping `enable` mid-subframe does not truncate the sweep. The current subframe completes, then the block drains.
- **Reset:** applies at any time, including mid-scan. It clears state, counters, shift register and FIFO, and discards in-flight pixels.
- **FIFO boundaries:**
  - Push and pop in the same cycle are legal at any occupancy.
  - The credit scheme makes overflow impossible; it is asserted in simulation.
- **Reset values:** `frame`=0, `subframe`=0, `x`=0, `y`=0, `pix_valid`=0, `pix_sof`/`pix_eol`/`pix_eof`=0, `busy`=0, state IDLE.

## Timing

- `frame`, `subframe`, `x`, `y` are registered outputs. Coordinates for issue N are stable from the edge that issues them until the next issue.
- `rgb24` is sampled `PAINT_LATENCY` clocks after coordinate presentation. The FIFO write occurs at the following edge.
- Pixel startup latency:
  - `enable` sampled high at edge E0 puts (0,0) on `x`/`y` after E0.
  - `pix_valid` first rises after edge E0+PAINT_LATENCY+1.
- A pixel transfers on any edge where `pix_valid`&&`pix_ready`. `pix_*` must hold stable while `pix_valid`=1 and `pix_ready`=0.
- With `pix_ready` held at 1, throughput is 1 pixel/clock: 4096 clocks per subframe and SUBFRAMES×4096 per frame.
- `frame`/`subframe` change in the cycle after (63,63) is presented. Pixels still in flight keep their own tags; `sof`/`eof` travel with the data.

## Structure

- **Shared package:** panel constants (`PANEL_W_BITS`=6, `PANEL_H_BITS`=6), the state encoding (IDLE/SCAN/DRAIN), and the pixel tag struct width (6+6+2).
- **Sub-module `pix_fifo`:** synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`.
  - Data width is 24+14 bits.
- Credit counter, shift register and FSM live in `paint_sequencer`.

## Test plan

- **Reset values:** assert `reset` 3 cycles, `enable`=0 → all outputs at reset values, `busy`=0, `pix_valid` never rises over 100 cycles.
- **Free-flowing subframe:** `enable`=1 for one subframe then 0, `pix_ready`=1, stub painter with `rgb24`={x,y} delayed `PAINT_LATENCY` →
  - exactly 4096 pixels in raster order, each `pix_rgb24` matching its `pix_x`/`pix_y`;
  - `pix_sof` only on (0,0), `pix_eof` only on (63,63), `pix_eol` 64 times;
  - first `pix_valid` at E0+2 (L=1), `busy` falls after drain.
- **Backpressure:** random `pix_ready` at 30% → no loss or duplication, `x` stalls while `credits`=0, FIFO count never exceeds 4.
- **Frame and subframe wrap:** run 8 subframes with `frame` preloaded via long run or force at 0xFFFF → `subframe` 7→0 coincides with `frame` 0xFFFF→0x0000, no bubble between subframes with `pix_ready`=1.
- **Early enable drop:** drop `enable` at pixel (10,5) → sweep completes to (63,63), then DRAIN→IDLE, with no further issues.
- **Reset mid-scan:** assert `reset` with 3 pixels in flight and 2 in the FIFO → next cycle `pix_valid`=0 and `x`=`y`=`frame`=0; after re-enable, the first output is (0,0) with `pix_sof`=1.
